// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: AXI response codes, default pixel width
// and a small response classification helper.
package fb_pkg;

  localparam int PIXEL_BITS_DEFAULT = 12;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;

  function automatic logic resp_is_error(input axi_resp_t resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/fb_reader_fifo.sv
// Synchronous response FIFO for fb_reader; the head entry is read straight
// from the storage flops, so data is visible the cycle after it is written.
module fb_reader_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_inc,
  input  logic [WIDTH-1:0] w_data,
  input  logic             r_inc,
  output logic [WIDTH-1:0] r_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign r_data = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (w_inc && !full) begin
      mem_d[wptr_q[AW-1:0]] = w_data;
      wptr_d = wptr_q + (AW+1)'(1);
    end
    if (r_inc && !empty) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_inc && full));

endmodule

// File: rtl/fb_reader.sv
// fb_reader: turns framebuffer addresses into AXI reads and returns colors in order.
// Define FB_READER_RRESP_CHECK_EN to zero errored beats and raise a sticky out_err.
module fb_reader
  import fb_pkg::*;
#(
  parameter int PIXEL_BITS     = PIXEL_BITS_DEFAULT,
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int DEPTH          = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      axi_tvalid,
  output logic                      axi_tready,
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  output logic                      out_axi_tvalid,
  input  logic                      out_axi_tready,
  output logic [PIXEL_BITS-1:0]     out_color,
  output logic                      out_err,
  output logic [AXI_ADDR_WIDTH-1:0] sram_axi_araddr,
  output logic                      sram_axi_arvalid,
  input  logic                      sram_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] sram_axi_rdata,
  input  logic [1:0]                sram_axi_rresp,
  input  logic                      sram_axi_rvalid,
  output logic                      sram_axi_rready
);

  localparam int            CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);

  logic                      active_q;
  logic [CW-1:0]             credits_used_q, credits_used_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                      arvalid_q, arvalid_d;
  logic                      in_hs, out_hs, r_hs;
  logic                      fifo_empty, fifo_full;
  logic [PIXEL_BITS-1:0]     w_color;
  logic                      unused_rdata;

  // Handshakes stay off until the first clock after reset release.
  assign axi_tready       = active_q && (credits_used_q < CREDIT_MAX) &&
                            (!arvalid_q || sram_axi_arready);
  assign sram_axi_rready  = active_q;
  assign sram_axi_araddr  = araddr_q;
  assign sram_axi_arvalid = arvalid_q;
  assign out_axi_tvalid   = !fifo_empty;

  assign in_hs        = axi_tvalid && axi_tready;
  assign out_hs       = out_axi_tvalid && out_axi_tready;
  assign r_hs         = sram_axi_rvalid && sram_axi_rready;
  assign unused_rdata = ^sram_axi_rdata;

  always_comb begin
    credits_used_d = credits_used_q;
    if (in_hs && !out_hs) begin
      credits_used_d = credits_used_q + CW'(1);
    end else if (!in_hs && out_hs) begin
      credits_used_d = credits_used_q - CW'(1);
    end

    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    if (in_hs) begin
      araddr_d  = addr;
      arvalid_d = 1'b1;
    end else if (sram_axi_arready) begin
      arvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q       <= 1'b0;
      credits_used_q <= '0;
      araddr_q       <= '0;
      arvalid_q      <= 1'b0;
    end else begin
      active_q       <= 1'b1;
      credits_used_q <= credits_used_d;
      araddr_q       <= araddr_d;
      arvalid_q      <= arvalid_d;
    end
  end

`ifdef FB_READER_RRESP_CHECK_EN
  logic err_q, err_d;
  logic resp_bad;

  // An errored beat still consumes its FIFO slot so ordering is preserved.
  assign resp_bad = resp_is_error(sram_axi_rresp);
  assign w_color  = resp_bad ? '0 : sram_axi_rdata[PIXEL_BITS-1:0];
  assign out_err  = err_q;

  always_comb begin
    err_d = err_q;
    if (r_hs && resp_bad) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  logic unused_rresp;

  assign unused_rresp = ^sram_axi_rresp;
  assign w_color      = sram_axi_rdata[PIXEL_BITS-1:0];
  assign out_err      = 1'b0;
`endif

  fb_reader_fifo #(
    .WIDTH (PIXEL_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .w_inc  (r_hs),
    .w_data (w_color),
    .r_inc  (out_hs),
    .r_data (out_color),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

endmodule

// File: tb/tb_fb_reader.sv
// Scoreboard bench for fb_reader with a one-cycle-latency SRAM read model.
module tb_fb_reader;
  import fb_pkg::*;

  localparam int PB    = 12;
  localparam int AW    = 20;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          axiTvalid = 1'b0;
  logic          axiTready;
  logic [AW-1:0] addrIn = '0;
  logic          outTvalid;
  logic          outTready = 1'b1;
  logic [PB-1:0] outColor;
  logic          outErr;
  logic [AW-1:0] sramAraddr;
  logic          sramArvalid;
  logic          sramArready = 1'b1;
  logic [DW-1:0] sramRdata = '0;
  logic [1:0]    sramRresp = 2'b00;
  logic          sramRvalid = 1'b0;
  logic          sramRready;

  int errors = 0;
  int checks = 0;
  int cycCount = 0;
  int outCount = 0;
  int trLowCount = 0;
  bit trackTready = 1'b0;
  logic [AW-1:0] errAddr = 20'h00302;

  logic [PB-1:0] expQ[$];
  logic [AW-1:0] memAddrQ[$];

  fb_reader #(
    .PIXEL_BITS     (PB),
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .DEPTH          (DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .axi_tvalid       (axiTvalid),
    .axi_tready       (axiTready),
    .addr             (addrIn),
    .out_axi_tvalid   (outTvalid),
    .out_axi_tready   (outTready),
    .out_color        (outColor),
    .out_err          (outErr),
    .sram_axi_araddr  (sramAraddr),
    .sram_axi_arvalid (sramArvalid),
    .sram_axi_arready (sramArready),
    .sram_axi_rdata   (sramRdata),
    .sram_axi_rresp   (sramRresp),
    .sram_axi_rvalid  (sramRvalid),
    .sram_axi_rready  (sramRready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycCount <= cycCount + 1;

  // Upper nibble is F so a missing truncation of rdata shows up in the color.
  function automatic logic [DW-1:0] memData(input logic [AW-1:0] a);
    return {4'hF, a[11:0] ^ 12'hAAC};
  endfunction

  function automatic logic [PB-1:0] expColor(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    d = memData(a);
    return d[PB-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Enter at a falling edge; leaves at the falling edge after the handshake.
  task automatic applyStimulus(input logic [AW-1:0] a, input logic [PB-1:0] exp, output int waited);
    waited = 0;
    axiTvalid = 1'b1;
    addrIn = a;
    #1;
    while (!axiTready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (axiTready) begin
      expQ.push_back(exp);
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: addr 0x%0h never accepted, tready=%0b", a, axiTready);
    end
    @(negedge clk);
    axiTvalid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d colors outstanding, expected 0", expQ.size());
    end
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_axi_tready"}, axiTready, 0);
    checkOutput({tag, "_arvalid"}, sramArvalid, 0);
    checkOutput({tag, "_araddr"}, sramAraddr, 0);
    checkOutput({tag, "_rready"}, sramRready, 0);
    checkOutput({tag, "_out_tvalid"}, outTvalid, 0);
    checkOutput({tag, "_out_color"}, outColor, 0);
    checkOutput({tag, "_out_err"}, outErr, 0);
  endtask

  // SRAM model: accepts AR beats and answers each one the following cycle.
  initial begin
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        memAddrQ.delete();
        sramRvalid = 1'b0;
        sramRresp  = AXI_RESP_OKAY;
      end else begin
        if (memAddrQ.size() > 0) begin
          a = memAddrQ.pop_front();
          sramRvalid = 1'b1;
          sramRdata  = memData(a);
          sramRresp  = (a == errAddr) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end else begin
          sramRvalid = 1'b0;
          sramRdata  = 16'hDEAD;
          sramRresp  = AXI_RESP_OKAY;
        end
        if (sramArvalid && sramArready) begin
          memAddrQ.push_back(sramAraddr);
        end
      end
    end
  end

  // Monitor: pops one expected color for every output handshake.
  initial begin
    logic [PB-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && outTvalid && outTready) begin
        outCount++;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_color: got 0x%0h, expected no output", outColor);
        end else begin
          e = expQ.pop_front();
          checkOutput("color", outColor, e);
        end
      end
      if (trackTready && !axiTready) trLowCount++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    int waitSum;
    int startCyc;
    int startOut;
    int badAr;
    int acceptedWhileStalled;
    logic [PB-1:0] errTable [5];

    repeat (3) @(negedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("release_axi_tready", axiTready, 1);
    checkOutput("release_rready", sramRready, 1);
    @(negedge clk);

    $display("[TB] single read");
    applyStimulus(20'h00010, 12'hABC, w);
    #1;
    checkOutput("single_arvalid", sramArvalid, 1);
    checkOutput("single_araddr", sramAraddr, 20'h00010);
    @(negedge clk);
    waitDrain();
    #1;
    checkOutput("single_credits", dut.credits_used_q, 0);
    @(negedge clk);

    $display("[TB] burst of 16");
    waitSum = 0;
    trLowCount = 0;
    trackTready = 1'b1;
    startCyc = cycCount;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(20'h00040 + 20'(i), expColor(20'h00040 + 20'(i)), w);
      waitSum += w;
    end
    trackTready = 1'b0;
    waitDrain();
    checkOutput("burst_accept_stalls", waitSum, 0);
    checkOutput("burst_tready_low", trLowCount, 0);
    checkOutput("burst_rate_ok", (cycCount - startCyc) <= 22, 1);

    $display("[TB] consumer stall");
    outTready = 1'b0;
    startOut = outCount;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(20'h00100 + 20'(i), expColor(20'h00100 + 20'(i)), w);
    end
    axiTvalid = 1'b1;
    addrIn = 20'h00104;
    acceptedWhileStalled = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (axiTready) acceptedWhileStalled++;
      @(negedge clk);
    end
    axiTvalid = 1'b0;
    checkOutput("stall_extra_accepts", acceptedWhileStalled, 0);
    checkOutput("stall_out_tvalid", outTvalid, 1);
    outTready = 1'b1;
    for (int i = 4; i < 10; i++) begin
      applyStimulus(20'h00100 + 20'(i), expColor(20'h00100 + 20'(i)), w);
    end
    waitDrain();
    checkOutput("stall_total_colors", outCount - startOut, 10);

    $display("[TB] arready held low");
    sramArready = 1'b0;
    applyStimulus(20'h00200, 12'h8AC, w);
    axiTvalid = 1'b1;
    addrIn = 20'h00201;
    badAr = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (sramAraddr !== 20'h00200 || sramArvalid !== 1'b1 || axiTready !== 1'b0) badAr++;
      @(negedge clk);
    end
    checkOutput("arstall_hold_violations", badAr, 0);
    sramArready = 1'b1;
    applyStimulus(20'h00201, 12'h8AD, w);
    waitDrain();

    $display("[TB] read response error beat");
    errTable[0] = 12'h9AC;
    errTable[1] = 12'h9AD;
`ifdef FB_READER_RRESP_CHECK_EN
    errTable[2] = 12'h000;
`else
    errTable[2] = 12'h9AE;
`endif
    errTable[3] = 12'h9AF;
    errTable[4] = 12'h9A8;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(20'h00300 + 20'(i), errTable[i], w);
    end
    waitDrain();
`ifdef FB_READER_RRESP_CHECK_EN
    checkOutput("err_flag", outErr, 1);
`else
    checkOutput("err_flag", outErr, 0);
`endif

    $display("[TB] reset mid-operation");
    outTready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(20'h00400 + 20'(i), expColor(20'h00400 + 20'(i)), w);
    end
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    outTready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rerelease_axi_tready", axiTready, 1);
    @(negedge clk);
    startOut = outCount;
    applyStimulus(20'h00020, 12'hA8C, w);
    waitDrain();
    checkOutput("postreset_colors", outCount - startOut, 1);
    checkOutput("postreset_err", outErr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
